matrix_data_loader: RTL and testbench
=====================================

# matrix_data_loader

Byte-serial loader and 2×2 matrix multiplier front end. It receives a framed stream of 8-bit bytes, qualified by a 2-bit control code: a dimension header, then the elements of matrix A and matrix B. It then multiplies the two matrices in an internal multiplier sub-module and holds the 2×2 product on a 64-bit result bus until the next frame completes. It sits between the off-chip byte interface and downstream result consumers.

## Interface
- `DATA_W`, default 8: width of the input byte and of each matrix element.
- `RES_W`, default 16: width of each product element.
- `N`, default 2: matrix dimension. Fixed at 2; other values are unsupported.
- `CLK`, input, 1: rising-edge clock.
- `RST_N`, input, 1: reset. One clock; synchronous, active-low.
- `data_in`, input, 8: stream byte, sampled on every `CLK` rising edge.
- `ctrl`, input, 2: qualifier for `data_in`. 2'd2 = IDLE/delimiter, 2'd1 = HEADER, 2'd0 = DATA, 2'd3 = ABORT.
- `res_mat`, output, 64: product C packed row-major. C00 = [63:48], C01 = [47:32], C10 = [31:16], C11 = [15:0].
- `res_valid`, output, 1: one-cycle pulse when `res_mat` has just been updated.

## Operation
- FSM states: IDLE, HDR, LOAD, CALC.
- **IDLE**
  - ctrl=1 → HDR; capture `data_in` as header byte 0.
  - ctrl=0 or ctrl=3 → ignored.
- **HDR**
  - Captures up to 4 header bytes: rows_A, cols_A, rows_B, cols_B. They are stored in a `dims` register only. Computation is always 2×2 and the header values are not checked.
  - A 5th or later ctrl=1 byte is ignored.
  - ctrl=0 → LOAD; this byte is element 0.
  - ctrl=2 → IDLE.
- **LOAD**
  - Each ctrl=0 byte is stored at element index k, which counts 0..7, unsigned.
  - k=0..3 → A00, A01, A10, A11.
  - k=4..7 → B00, B01, B10, B11.
  - Capturing k=7 → CALC.
  - ctrl=2 before 8 elements → IDLE; the frame is discarded and `res_mat` is unchanged.
  - ctrl=1 → HDR; the frame restarts, the element count clears, and the byte is taken as header byte 0.
- **CALC**, one cycle:
  - Cij = Ai0·B0j + Ai1·B1j, unsigned.
  - Each 8×8 product is 16 bits; the 17-bit sum is truncated to 16 bits (mod 2^16).
  - Registers `res_mat`, pulses `res_valid`, → IDLE.
  - Input during CALC is ignored.
- **ctrl=3 (ABORT)**: from any state → IDLE; the partial frame is discarded.
- After 8 elements, further ctrl=0 bytes (from IDLE) are ignored until the next ctrl=1.

## Timing
- Inputs are sampled on the rising edge of `CLK`.
- Latency: edge that samples element 7 = T. FSM is in CALC during T→T+1. `res_mat` and `res_valid` are valid after edge T+1.
- Minimum frame: 1 header byte, 8 data bytes, 1 delimiter (10 cycles). A nominal frame is 2, 1×4, 0×8, 2 (14 cycles). Frames may be back-to-back.
- `res_mat` holds its value until the next successful CALC. `res_valid` is 1 for exactly one cycle.
- Reset (`RST_N`=0 at an edge), including mid-frame:
  - FSM goes to IDLE.
  - Element and header counters clear.
  - All A/B/`dims` registers go to 0.
  - `res_mat` = 0, `res_valid` = 0.

## Structure
- Shared package `mat_pkg` holds:
  - The ctrl enum: CTRL_DATA=0, CTRL_HDR=1, CTRL_IDLE=2, CTRL_ABORT=3.
  - The state enum.
  - `DATA_W`, `RES_W`, `N`, and the element-count constant 8.
- One sub-module `mat_mult_2x2`, instance name `mult`:
  - Combinational.
  - Inputs: packed A and B, 32 bits each.
  - Output: packed C, 64 bits.
  - The loader owns all registers, including `res_mat`. Hierarchical `mult.res_mat` is the combinational product.

## Test plan
- **Single frame.** Reset, then 2; 1×4 of 2; 0 with A=[1,2,3,4], B=[5,6,7,8]; then 2. Required: `res_mat` = {16'd19, 16'd22, 16'd43, 16'd50} and one `res_valid` pulse at T+1.
- **Overflow wrap.** A=[255,255,255,255], B=[255,255,255,255]. Each element = 130050 mod 65536 = 64514 (16'hFC02).
- **Truncated frame.** Header, then 5 data bytes, then ctrl=2. Required: `res_mat` keeps its previous value and no `res_valid`.
- **Reset mid-LOAD.** `RST_N` low after 3 data bytes. Required: `res_mat` = 0 next cycle. A following full frame computes correctly, with no stale elements.
- **Back-to-back 3 frames with random bytes.** Required: each result matches a software 2×2 model (mod 2^16), and each result holds until the next pulse.
- **ABORT and restart.** ctrl=3 mid-LOAD, then ctrl=1 mid-LOAD. Required: the partial frame is discarded, and the element index restarts at 0.

Source files
------------

// File: rtl/mat_pkg.sv
`default_nettype none
// ============================================================================
// Package : mat_pkg
// Brief   : Shared constants and enums for the 2x2 matrix loader/multiplier.
// Rev     : 1.0  initial release
// ============================================================================
package mat_pkg;

    localparam int DATA_W      = 8;
    localparam int RES_W       = 16;
    localparam int N           = 2;
    localparam int C_ELEM_CNT  = 8;
    localparam int C_HDR_CNT   = 4;

    typedef enum logic [1:0] {
        CTRL_DATA  = 2'd0,
        CTRL_HDR   = 2'd1,
        CTRL_IDLE  = 2'd2,
        CTRL_ABORT = 2'd3
    } ctrl_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_LOAD = 2'd2,
        ST_CALC = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/mat_mult_2x2.sv
`default_nettype none
// ============================================================================
// Module  : mat_mult_2x2
// Brief   : Combinational row-major matrix product, element sums mod 2^RES_W.
// Rev     : 1.0  initial release
// ============================================================================
module mat_mult_2x2 #(
    parameter int DATA_W = mat_pkg::DATA_W,
    parameter int RES_W  = mat_pkg::RES_W,
    parameter int N      = mat_pkg::N
) (
    input  logic [N*N*DATA_W-1:0] a_mat,
    input  logic [N*N*DATA_W-1:0] b_mat,
    output logic [N*N*RES_W-1:0]  res_mat
);
    import mat_pkg::*;

    logic [DATA_W-1:0] w_a_el;
    logic [DATA_W-1:0] w_b_el;
    logic [RES_W-1:0]  w_acc;

    // Element (r,c) sits at the top of the packed word for index 0.
    always_comb begin
        res_mat = '0;
        w_acc   = '0;
        w_a_el  = '0;
        w_b_el  = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                w_acc = '0;
                for (int k = 0; k < N; k++) begin
                    w_a_el = a_mat[(N*N-1-(i*N+k))*DATA_W +: DATA_W];
                    w_b_el = b_mat[(N*N-1-(k*N+j))*DATA_W +: DATA_W];
                    w_acc  = w_acc + RES_W'(w_a_el) * RES_W'(w_b_el);
                end
                res_mat[(N*N-1-(i*N+j))*RES_W +: RES_W] = w_acc;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/matrix_data_loader.sv
`default_nettype none
// ============================================================================
// Module  : matrix_data_loader
// Brief   : Framed byte-stream loader feeding a 2x2 multiplier; holds result.
// Rev     : 1.0  initial release
// ============================================================================
module matrix_data_loader #(
    parameter int DATA_W = mat_pkg::DATA_W,
    parameter int RES_W  = mat_pkg::RES_W,
    parameter int N      = mat_pkg::N
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [DATA_W-1:0]    data_in,
    input  logic [1:0]           ctrl,
    output logic [N*N*RES_W-1:0] res_mat,
    output logic                 res_valid
);
    import mat_pkg::*;

    localparam int                IDX_W       = $clog2(C_ELEM_CNT);
    localparam logic [IDX_W-1:0]  C_ELEM_LAST = IDX_W'(C_ELEM_CNT - 1);
    localparam logic [IDX_W-1:0]  C_IDX_ONE   = IDX_W'(1);
    localparam logic [2:0]        C_HDR_MAX   = 3'(C_HDR_CNT);
    localparam logic [2:0]        C_HDR_ONE   = 3'd1;

    state_e             r_state;
    state_e             w_state_next;
    ctrl_e              w_ctrl;

    logic [DATA_W-1:0]  r_elem [C_ELEM_CNT];
    logic [DATA_W-1:0]  r_dims [C_HDR_CNT];
    logic [IDX_W-1:0]   r_elem_idx;
    logic [2:0]         r_hdr_cnt;

    logic               w_hdr_first;
    logic               w_hdr_more;
    logic               w_elem_we;
    logic               w_calc;

    logic [N*N*DATA_W-1:0] w_a_pk;
    logic [N*N*DATA_W-1:0] w_b_pk;
    logic [N*N*RES_W-1:0]  w_product;
    logic                  w_unused_dims;

    assign w_ctrl = ctrl_e'(ctrl);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_hdr_first  = 1'b0;
        w_hdr_more   = 1'b0;
        w_elem_we    = 1'b0;
        w_calc       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_ctrl == CTRL_HDR) begin
                    w_state_next = ST_HDR;
                    w_hdr_first  = 1'b1;
                end
            end
            ST_HDR: begin
                case (w_ctrl)
                    CTRL_HDR:  w_hdr_more = (r_hdr_cnt < C_HDR_MAX);
                    CTRL_DATA: begin
                        w_elem_we    = 1'b1;
                        w_state_next = ST_LOAD;
                    end
                    default:   w_state_next = ST_IDLE;
                endcase
            end
            ST_LOAD: begin
                case (w_ctrl)
                    CTRL_DATA: begin
                        w_elem_we = 1'b1;
                        if (r_elem_idx == C_ELEM_LAST) begin
                            w_state_next = ST_CALC;
                        end
                    end
                    // A new header mid-load restarts the frame from scratch.
                    CTRL_HDR: begin
                        w_state_next = ST_HDR;
                        w_hdr_first  = 1'b1;
                    end
                    default:   w_state_next = ST_IDLE;
                endcase
            end
            ST_CALC: begin
                w_calc       = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_elem_idx <= '0;
            r_hdr_cnt  <= '0;
            res_mat    <= '0;
            res_valid  <= 1'b0;
            for (int i = 0; i < C_ELEM_CNT; i++) begin
                r_elem[i] <= '0;
            end
            for (int i = 0; i < C_HDR_CNT; i++) begin
                r_dims[i] <= '0;
            end
        end else begin
            res_valid <= w_calc;
            if (w_calc) begin
                res_mat <= w_product;
            end
            if (w_hdr_first) begin
                r_dims[0]  <= data_in;
                r_hdr_cnt  <= C_HDR_ONE;
                r_elem_idx <= '0;
            end else if (w_hdr_more) begin
                r_dims[r_hdr_cnt[1:0]] <= data_in;
                r_hdr_cnt              <= r_hdr_cnt + C_HDR_ONE;
            end
            // Index wraps 7 -> 0 on the last element, ready for the next frame.
            if (w_elem_we) begin
                r_elem[r_elem_idx] <= data_in;
                r_elem_idx         <= r_elem_idx + C_IDX_ONE;
            end
        end
    end

    assign w_a_pk = {r_elem[0], r_elem[1], r_elem[2], r_elem[3]};
    assign w_b_pk = {r_elem[4], r_elem[5], r_elem[6], r_elem[7]};

    // Header dimensions are kept for visibility only; computation is fixed 2x2.
    assign w_unused_dims = ^{r_dims[0], r_dims[1], r_dims[2], r_dims[3]};

    mat_mult_2x2 #(
        .DATA_W (DATA_W),
        .RES_W  (RES_W),
        .N      (N)
    ) mult (
        .a_mat   (w_a_pk),
        .b_mat   (w_b_pk),
        .res_mat (w_product)
    );

endmodule
`default_nettype wire

// File: tb/tb_matrix_data_loader.sv
`default_nettype none
// ============================================================================
// Module  : tb_matrix_data_loader
// Brief   : Randomised frame stimulus against a behavioural 2x2 product model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_matrix_data_loader;

    logic        CLK     = 1'b0;
    logic        RST_N   = 1'b0;
    logic [7:0]  data_in = 8'd0;
    logic [1:0]  ctrl    = 2'd2;
    logic [63:0] res_mat;
    logic        res_valid;

    matrix_data_loader #(
        .DATA_W (8),
        .RES_W  (16),
        .N      (2)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .data_in   (data_in),
        .ctrl      (ctrl),
        .res_mat   (res_mat),
        .res_valid (res_valid)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        bit          rst;
        logic [63:0] val;
    } ev_t;

    ev_t         evq[$];
    logic [63:0] exp_hold  = 64'd0;
    bit          exp_pulse = 1'b0;
    bit          chk_en    = 1'b0;
    int          n_tests   = 0;
    int          n_fail    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Plain-integer 2x2 product, each element reduced mod 65536.
    function automatic logic [63:0] model_mult(input logic [31:0] a, input logic [31:0] b);
        int          ae[4];
        int          be[4];
        int          s;
        logic [63:0] r;
        for (int k = 0; k < 4; k++) begin
            ae[k] = int'(a[31-8*k -: 8]);
            be[k] = int'(b[31-8*k -: 8]);
        end
        r = 64'd0;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                s = (ae[2*i] * be[j] + ae[2*i+1] * be[2+j]) % 65536;
                r[63-16*(2*i+j) -: 16] = s[15:0];
            end
        end
        return r;
    endfunction

    always @(negedge CLK) begin
        if (chk_en) begin
            exp_pulse = 1'b0;
            if (evq.size() > 0 && evq[0].cyc <= cyc) begin
                if (evq[0].cyc < cyc) begin
                    chk("event_late", 64'(cyc), 64'(evq[0].cyc));
                end
                if (evq[0].rst) begin
                    exp_hold = 64'd0;
                end else begin
                    exp_pulse = 1'b1;
                    exp_hold  = evq[0].val;
                end
                void'(evq.pop_front());
            end
            chk("res_valid", {63'd0, res_valid}, {63'd0, exp_pulse});
            chk("res_mat", res_mat, exp_hold);
        end
    end

    task automatic send(input logic [1:0] c, input logic [7:0] d);
        ctrl    = c;
        data_in = d;
        @(posedge CLK);
        #1;
    endtask

    task automatic send_hdrs(input int nh);
        for (int i = 0; i < nh; i++) send(2'd1, 8'($urandom_range(1, 4)));
    endtask

    // Sends the first m elements of A then B; completing all 8 schedules a result.
    task automatic send_data(input logic [31:0] a, input logic [31:0] b, input int m);
        ev_t        e;
        logic [7:0] d;
        for (int k = 0; k < m; k++) begin
            d = (k < 4) ? a[31-8*k -: 8] : b[31-8*(k-4) -: 8];
            if (k == 7) begin
                e.cyc = cyc + 2;
                e.rst = 1'b0;
                e.val = model_mult(a, b);
                evq.push_back(e);
            end
            send(2'd0, d);
        end
    endtask

    task automatic full_frame(input logic [31:0] a, input logic [31:0] b, input int nh);
        send_hdrs(nh);
        send_data(a, b, 8);
        send(2'd2, 8'($urandom));
    endtask

    task automatic partial(input int nh, input int m, input int term);
        send_hdrs(nh);
        send_data($urandom, $urandom, m);
        if (term != 0) send(2'(term), 8'($urandom));
    endtask

    task automatic do_reset();
        ev_t e;
        e.cyc = cyc + 1;
        e.rst = 1'b1;
        e.val = 64'd0;
        evq.push_back(e);
        RST_N   = 1'b0;
        ctrl    = 2'd0;
        data_in = 8'($urandom);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
    endtask

    // Idle-time bytes that must be ignored: stray data, delimiters, aborts.
    task automatic noise(input int n);
        int r;
        for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 2);
            send((r == 0) ? 2'd0 : ((r == 1) ? 2'd2 : 2'd3), 8'($urandom));
        end
    endtask

    initial begin
        int kind;
        RST_N = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        chk("reset_res_mat", res_mat, 64'd0);
        chk("reset_res_valid", {63'd0, res_valid}, 64'd0);
        chk_en = 1'b1;

        // Nominal frame with known product.
        send(2'd2, 8'd0);
        for (int i = 0; i < 4; i++) send(2'd1, 8'd2);
        send_data(32'h01020304, 32'h05060708, 8);
        send(2'd2, 8'd0);
        chk("single_res_mat", res_mat, 64'h0013_0016_002B_0032);
        chk("single_pulse", {63'd0, res_valid}, 64'd1);

        // Every element wraps: 2*255*255 mod 65536.
        full_frame(32'hFFFFFFFF, 32'hFFFFFFFF, 1);
        chk("overflow_res_mat", res_mat, 64'hFC02_FC02_FC02_FC02);

        // Truncated frame leaves the held result alone.
        partial(2, 5, 2);
        noise(3);
        chk("truncated_hold", res_mat, 64'hFC02_FC02_FC02_FC02);

        // Reset in the middle of loading.
        partial(1, 3, 0);
        do_reset();
        chk("midload_reset", res_mat, 64'd0);
        full_frame($urandom, $urandom, 2);

        // Back-to-back frames.
        for (int f = 0; f < 3; f++) full_frame($urandom, $urandom, 1);

        // Abort mid-load, then header restart mid-load; identity A keeps B.
        partial(2, 4, 3);
        partial(1, 3, 0);
        full_frame(32'h01000001, 32'h09080706, 1);
        chk("abort_restart", res_mat, 64'h0009_0008_0007_0006);

        for (int it = 0; it < 40; it++) begin
            noise($urandom_range(0, 3));
            kind = $urandom_range(0, 3);
            case (kind)
                0:       full_frame($urandom, $urandom, $urandom_range(1, 6));
                1:       partial($urandom_range(1, 6), $urandom_range(0, 7), 2);
                2:       partial($urandom_range(1, 6), $urandom_range(0, 7), 3);
                default: begin
                    partial($urandom_range(1, 3), $urandom_range(0, 7), 0);
                    full_frame($urandom, $urandom, $urandom_range(1, 6));
                end
            endcase
        end

        repeat (4) send(2'd2, 8'd0);
        chk("events_drained", 64'(evq.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
